// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: state encodings and default widths.
package instruction_fetch_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int ADDR_WIDTH     = 8;
  localparam int TIMEOUT_CYCLES = 15;
  localparam int WORD_BYTE_SIZE = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_WAIT = 2'b01,
    FETCH_HOLD = 2'b10
  } fetch_state_e;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_watchdog.sv
// fetch_watchdog: counts stalled WAIT cycles; only built when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog #(
  parameter int TimeoutCycles = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Count_En,
  output logic Expired
);

  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  // Next count: clear wins over counting.
  always_comb begin
    count_d = count_q;
    if (Clear) begin
      count_d = {CntW{1'b0}};
    end else if (Count_En) begin
      count_d = count_q + CntW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= {CntW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the stalled cycle that completes the TimeoutCycles-th wait.
  assign Expired = Count_En && !Clear && (count_q == CntW'(TimeoutCycles - 1));

endmodule : fetch_watchdog
`endif

// File: rtl/instruction_fetch.sv
// Fetch stage: PC -> instruction memory read -> IR with valid/ack handshake.
// Optional read timeout with sticky Fault is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int DataWidth     = DATA_WIDTH,
  parameter int AddrWidth     = ADDR_WIDTH,
  parameter int TimeoutCycles = TIMEOUT_CYCLES
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 Flush,
  input  logic [DataWidth-1:0] PC_In,
  output logic                 PC_Inc,
  output logic [AddrWidth-1:0] Mem_Addr,
  output logic                 Mem_Rd,
  input  logic [DataWidth-1:0] Mem_DIn,
  input  logic                 Mem_Rdy,
  output logic [DataWidth-1:0] IR,
  output logic                 IR_Valid,
  input  logic                 IR_Ack,
  output logic                 Fault
);

  fetch_state_e         state_q, state_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_rd_q, mem_rd_d;
  logic [DataWidth-1:0] ir_q, ir_d;
  logic                 ir_valid_q, ir_valid_d;
  logic                 pc_inc_q, pc_inc_d;

  logic fault_s;
  logic timeout_s;
  logic start_s;
  logic wd_clear_s;
  logic wd_count_en_s;

  // Upper PC bits only select beyond the instruction memory and wrap away.
  logic unused_pc_hi_s;
  assign unused_pc_hi_s = ^PC_In[DataWidth-1:AddrWidth] ^ (WORD_BYTE_SIZE > 0) ^ (TimeoutCycles > 0);

  assign start_s       = Run && !Flush && !fault_s;
  assign wd_clear_s    = Flush || ((state_q == FETCH_IDLE) && start_s);
  assign wd_count_en_s = (state_q == FETCH_WAIT) && !Mem_Rdy && !Flush;

`ifdef FETCH_TIMEOUT_EN
  logic fault_q, fault_d;

  fetch_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clear    (wd_clear_s),
    .Count_En (wd_count_en_s),
    .Expired  (timeout_s)
  );

  // Fault is sticky until Reset; Flush deliberately leaves it alone.
  always_comb begin
    fault_d = fault_q;
    if (timeout_s) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  // Fault flag register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_s = fault_q;
`else
  logic unused_wd_s;
  assign unused_wd_s = wd_clear_s ^ wd_count_en_s;
  assign timeout_s   = 1'b0;
  assign fault_s     = 1'b0;
`endif

  // Next-state and registered-output logic for the fetch sequencer.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_inc_d   = 1'b0;

    case (state_q)
      FETCH_IDLE: begin
        if (start_s) begin
          mem_addr_d = PC_In[AddrWidth-1:0];
          mem_rd_d   = 1'b1;
          state_d    = FETCH_WAIT;
        end else begin
          mem_rd_d   = 1'b0;
          state_d    = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        // Flush discards even data that arrives in the same cycle.
        if (Flush) begin
          mem_rd_d = 1'b0;
          state_d  = FETCH_IDLE;
        end else if (Mem_Rdy) begin
          ir_d       = Mem_DIn;
          ir_valid_d = 1'b1;
          mem_rd_d   = 1'b0;
          pc_inc_d   = 1'b1;
          state_d    = FETCH_HOLD;
        end else if (timeout_s) begin
          mem_rd_d = 1'b0;
          state_d  = FETCH_IDLE;
        end else begin
          state_d  = FETCH_WAIT;
        end
      end
      FETCH_HOLD: begin
        if (Flush || IR_Ack) begin
          ir_valid_d = 1'b0;
          state_d    = FETCH_IDLE;
        end else begin
          state_d    = FETCH_HOLD;
        end
      end
      default: begin
        mem_rd_d   = 1'b0;
        ir_valid_d = 1'b0;
        state_d    = FETCH_IDLE;
      end
    endcase
  end

  // Sequencer and output registers; Reset overrides every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= FETCH_IDLE;
      mem_addr_q <= {AddrWidth{1'b0}};
      mem_rd_q   <= 1'b0;
      ir_q       <= {DataWidth{1'b0}};
      ir_valid_q <= 1'b0;
      pc_inc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_inc_q   <= pc_inc_d;
    end
  end

  assign Mem_Addr = mem_addr_q;
  assign Mem_Rd   = mem_rd_q;
  assign IR       = ir_q;
  assign IR_Valid = ir_valid_q;
  assign PC_Inc   = pc_inc_q;
  assign Fault    = fault_s;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a transaction-level reference model.
module tb_instruction_fetch;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          Clk = 1'b0;
  logic          Reset, Run, Flush, Mem_Rdy, IR_Ack;
  logic [DW-1:0] PC_In, Mem_DIn;
  logic          PC_Inc, Mem_Rd, IR_Valid, Fault;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] IR;

  int tests = 0;
  int fails = 0;

  instruction_fetch #(.DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Flush(Flush), .PC_In(PC_In),
    .PC_Inc(PC_Inc), .Mem_Addr(Mem_Addr), .Mem_Rd(Mem_Rd), .Mem_DIn(Mem_DIn),
    .Mem_Rdy(Mem_Rdy), .IR(IR), .IR_Valid(IR_Valid), .IR_Ack(IR_Ack), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  // Reference model: outputs follow from the handshake rules, tracked as
  // "read outstanding" / "instruction held" rather than as a state machine.
  logic          m_started = 1'b0;
  logic [AW-1:0] m_addr;
  logic          m_rd, m_valid, m_inc, m_fault;
  logic [DW-1:0] m_ir;
  int            m_wcnt;

  always @(posedge Clk) begin
    m_started <= 1'b1;
    m_inc     <= 1'b0;
    if (Reset) begin
      m_addr <= '0; m_rd <= 1'b0; m_ir <= '0; m_valid <= 1'b0;
      m_fault <= 1'b0; m_wcnt <= 0;
    end else if (m_valid) begin
      if (Flush || IR_Ack) m_valid <= 1'b0;
    end else if (m_rd) begin
      if (Flush) m_rd <= 1'b0;
      else if (Mem_Rdy) begin
        m_ir <= Mem_DIn; m_valid <= 1'b1; m_rd <= 1'b0; m_inc <= 1'b1;
      end
`ifdef FETCH_TIMEOUT_EN
      else if (m_wcnt == TO - 1) begin
        m_rd <= 1'b0; m_fault <= 1'b1;
      end else m_wcnt <= m_wcnt + 1;
`endif
    end else if (Run && !Flush && !m_fault) begin
      m_addr <= PC_In[AW-1:0]; m_rd <= 1'b1; m_wcnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (m_started) begin
      chk("model.Mem_Rd",   {31'd0, Mem_Rd},   {31'd0, m_rd});
      chk("model.Mem_Addr", {24'd0, Mem_Addr}, {24'd0, m_addr});
      chk("model.IR",       {16'd0, IR},       {16'd0, m_ir});
      chk("model.IR_Valid", {31'd0, IR_Valid}, {31'd0, m_valid});
      chk("model.PC_Inc",   {31'd0, PC_Inc},   {31'd0, m_inc});
      chk("model.Fault",    {31'd0, Fault},    {31'd0, m_fault});
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  int rd_cnt;
  int n;

  initial begin
    Reset = 1'b1; Run = 1'b1; Flush = 1'b0; Mem_Rdy = 1'b1; IR_Ack = 1'b0;
    PC_In = 16'h0005; Mem_DIn = 16'hA55A;
    tick(); tick();
    chk("reset.Mem_Rd", {31'd0, Mem_Rd}, 32'd0);
    chk("reset.IR_Valid", {31'd0, IR_Valid}, 32'd0);
    chk("reset.IR", {16'd0, IR}, 32'd0);
    chk("reset.Mem_Addr", {24'd0, Mem_Addr}, 32'd0);

    // Basic fetch at PC 5, data ready in first WAIT cycle; Run dropped mid-fetch.
    Reset = 1'b0;
    tick();
    chk("f1.addr", {24'd0, Mem_Addr}, 32'h05);
    chk("f1.rd", {31'd0, Mem_Rd}, 32'd1);
    Run = 1'b0;
    tick();
    chk("f1.ir", {16'd0, IR}, 32'hA55A);
    chk("f1.inc", {31'd0, PC_Inc}, 32'd1);
    IR_Ack = 1'b1; PC_In = 16'h0006;
    tick();
    chk("f1.inc_once", {31'd0, PC_Inc}, 32'd0);
    chk("f1.valid_clr", {31'd0, IR_Valid}, 32'd0);

    // Next fetch from PC 6 with memory stalled 4 cycles.
    IR_Ack = 1'b0; Run = 1'b1; Mem_Rdy = 1'b0;
    tick();
    chk("f2.addr", {24'd0, Mem_Addr}, 32'h06);
    rd_cnt = Mem_Rd ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (Mem_Rd) rd_cnt++;
      chk("f2.addr_stable", {24'd0, Mem_Addr}, 32'h06);
    end
    Mem_Rdy = 1'b1; Mem_DIn = 16'hBEEF;
    tick();
    chk("f2.rd_cycles", rd_cnt, 32'd5);
    chk("f2.ir", {16'd0, IR}, 32'hBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("f2.hold_valid", {31'd0, IR_Valid}, 32'd1);
      chk("f2.hold_no_rd", {31'd0, Mem_Rd}, 32'd0);
    end
    IR_Ack = 1'b1; Run = 1'b0;
    tick();
    IR_Ack = 1'b0;

    // Ack with nothing held is ignored.
    IR_Ack = 1'b1;
    tick();
    IR_Ack = 1'b0;

    // Address wrap: only the low byte of the PC reaches memory.
    PC_In = 16'h01FF; Run = 1'b1; Mem_DIn = 16'h1111;
    tick();
    chk("wrap.addr", {24'd0, Mem_Addr}, 32'hFF);
    Run = 1'b0;
    tick();
    IR_Ack = 1'b1;
    tick();
    IR_Ack = 1'b0;

    // Flush coincident with Mem_Rdy drops the data.
    PC_In = 16'h0020; Run = 1'b1; Mem_Rdy = 1'b0;
    tick();
    Mem_Rdy = 1'b1; Mem_DIn = 16'h1234; Flush = 1'b1; Run = 1'b0;
    tick();
    chk("flush.inc", {31'd0, PC_Inc}, 32'd0);
    chk("flush.valid", {31'd0, IR_Valid}, 32'd0);
    chk("flush.ir_kept", {16'd0, IR}, 32'h1111);
    Flush = 1'b0; PC_In = 16'h0040; Run = 1'b1; Mem_DIn = 16'h5678;
    tick();
    chk("flush.next_addr", {24'd0, Mem_Addr}, 32'h40);
    Run = 1'b0;
    tick();
    chk("flush.next_ir", {16'd0, IR}, 32'h5678);
    // Flush in HOLD beats a simultaneous ack and drops the instruction.
    Flush = 1'b1; IR_Ack = 1'b1;
    tick();
    chk("hold_flush.valid", {31'd0, IR_Valid}, 32'd0);
    Flush = 1'b0; IR_Ack = 1'b0;

    // Stalled memory: timeout behaviour depends on the build.
    PC_In = 16'h0010; Run = 1'b1; Mem_Rdy = 1'b0;
    tick();
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    while (!Fault && n < 40) begin
      tick();
      n++;
    end
    chk("to.cycles", n, TO);
    chk("to.rd", {31'd0, Mem_Rd}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("to.run_ignored", {31'd0, Mem_Rd}, 32'd0);
    chk("to.sticky", {31'd0, Fault}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0; Run = 1'b0;
    tick();
    chk("to.reset_clears", {31'd0, Fault}, 32'd0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("stall.rd_held", {31'd0, Mem_Rd}, 32'd1);
    chk("stall.no_fault", {31'd0, Fault}, 32'd0);
    Flush = 1'b1; Run = 1'b0;
    tick();
    Flush = 1'b0;
`endif
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_instruction_fetch
